tl_ul_regfile_slave: RTL

- TileLink-UL slave endpoint that sits directly downstream of the A/D channel buffer pair.
- Consumes A-channel requests: Get, PutFullData, PutPartialData.
- Services them from a small 32-bit register file and returns one D-channel response per request.
- Fully pipelined: one request per cycle, single-entry D output register, in-order responses.

---
 rtl/tl_ul_regfile_slave.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/tl_ul_regfile_slave.sv
// TileLink-UL slave endpoint backed by a small 32-bit register file.
// It accepts one A-channel request per cycle and answers each one with a
// single in-order D-channel response. The top register is a read-only ID word.
module tl_ul_regfile_slave #(
   parameter int          NREGS    = 16,
   parameter int          ADDR_W   = 14,
   parameter int          SRC_W    = 4,
   parameter logic [31:0] ID_VALUE = 32'h0000_E21A
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [2:0]        a_opcode,
   input  logic [2:0]        a_param,
   input  logic [2:0]        a_size,
   input  logic [SRC_W-1:0]  a_source,
   input  logic [ADDR_W-1:0] a_address,
   input  logic [3:0]        a_mask,
   input  logic [31:0]       a_data,
   input  logic              a_corrupt,
   output logic              d_valid,
   input  logic              d_ready,
   output logic [2:0]        d_opcode,
   output logic [1:0]        d_param,
   output logic [2:0]        d_size,
   output logic [SRC_W-1:0]  d_source,
   output logic              d_denied,
   output logic [31:0]       d_data,
   output logic              d_corrupt
);

   localparam int IDX_W = $clog2(NREGS);
   localparam logic [IDX_W-1:0] ID_IDX = IDX_W'(NREGS - 1);

   localparam logic [2:0] OP_PUT_FULL    = 3'd0;
   localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
   localparam logic [2:0] OP_GET         = 3'd4;
   localparam logic [2:0] D_ACK          = 3'd0;
   localparam logic [2:0] D_ACK_DATA     = 3'd1;

   // The top entry exists only to keep indexing in bounds; reads of it return ID_VALUE.
   logic [31:0]      regs_q [NREGS];

   logic             dValid_q;
   logic [2:0]       dOpcode_q;
   logic [2:0]       dSize_q;
   logic [SRC_W-1:0] dSource_q;
   logic             dDenied_q;
   logic [31:0]      dData_q;
   logic             dCorrupt_q;

   logic [2:0]       dOpcode_d;
   logic [31:0]      dData_d;
   logic             dCorrupt_d;

   logic             fire;
   logic [IDX_W-1:0] idx;
   logic             inRange;
   logic             isGet;
   logic             isPutFull;
   logic             isPut;
   logic [3:0]       laneMask;
   logic             aligned;
   logic             denied;
   logic             writeEn;
   logic [31:0]      readData;
   logic             unusedParam;

   assign unusedParam = ^a_param;

   assign a_ready   = reset & (~dValid_q | d_ready);
   assign fire      = a_valid & a_ready;

   assign idx       = a_address[IDX_W+1:2];
   assign inRange   = (a_address[ADDR_W-1:IDX_W+2] == '0);
   assign isGet     = (a_opcode == OP_GET);
   assign isPutFull = (a_opcode == OP_PUT_FULL);
   assign isPut     = isPutFull | (a_opcode == OP_PUT_PARTIAL);

   assign readData  = (idx == ID_IDX) ? ID_VALUE : regs_q[idx];

   // Byte lanes a full-width access of this size/address would touch, and whether it is aligned.
   always_comb begin
      laneMask = 4'h0;
      aligned  = 1'b0;
      case (a_size)
         3'd0: begin
            laneMask = 4'b0001 << a_address[1:0];
            aligned  = 1'b1;
         end
         3'd1: begin
            laneMask = 4'b0011 << a_address[1:0];
            aligned  = ~a_address[0];
         end
         3'd2: begin
            laneMask = 4'hF;
            aligned  = (a_address[1:0] == 2'b00);
         end
         default: begin
            laneMask = 4'h0;
            aligned  = 1'b0;
         end
      endcase
   end

   assign denied = ~(isGet | isPut)
                 | ~inRange
                 | (a_size > 3'd2)
                 | ~aligned
                 | (isPutFull & (a_mask != laneMask))
                 | (isPut & a_corrupt)
                 | (isPut & (idx == ID_IDX));

   assign writeEn = fire & isPut & ~denied;

   // Build the response payload; unsupported data-bearing opcodes answer with poisoned empty data.
   always_comb begin
      dOpcode_d  = D_ACK;
      dData_d    = 32'h0;
      dCorrupt_d = 1'b0;
      if (isGet) begin
         dOpcode_d  = D_ACK_DATA;
         dData_d    = denied ? 32'h0 : readData;
         dCorrupt_d = denied;
      end else if (isPut) begin
         dOpcode_d  = D_ACK;
      end else if (a_opcode[2]) begin
         dOpcode_d  = D_ACK_DATA;
         dCorrupt_d = 1'b1;
      end
   end

   // Register file update: byte-lane writes land on the accepting edge.
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= 32'h0;
         end
      end else if (writeEn) begin
         for (int b = 0; b < 4; b++) begin
            if (a_mask[b]) begin
               regs_q[idx][8*b +: 8] <= a_data[8*b +: 8];
            end
         end
      end
   end

   // Single-entry D output register: load on accept, hold until the consumer takes it.
   always_ff @(posedge clock) begin
      if (!reset) begin
         dValid_q   <= 1'b0;
         dOpcode_q  <= 3'd0;
         dSize_q    <= 3'd0;
         dSource_q  <= '0;
         dDenied_q  <= 1'b0;
         dData_q    <= 32'h0;
         dCorrupt_q <= 1'b0;
      end else if (fire) begin
         dValid_q   <= 1'b1;
         dOpcode_q  <= dOpcode_d;
         dSize_q    <= a_size;
         dSource_q  <= a_source;
         dDenied_q  <= denied;
         dData_q    <= dData_d;
         dCorrupt_q <= dCorrupt_d;
      end else if (d_ready) begin
         dValid_q   <= 1'b0;
      end
   end

   assign d_valid   = dValid_q;
   assign d_opcode  = dOpcode_q;
   assign d_param   = 2'b00;
   assign d_size    = dSize_q;
   assign d_source  = dSource_q;
   assign d_denied  = dDenied_q;
   assign d_data    = dData_q;
   assign d_corrupt = dCorrupt_q;

endmodule
